// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle between the EX stage and alu_seq
interface alu_seq_if #(parameter int WIDTH = 32);
  logic kill, in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0] op;
  logic [WIDTH-1:0] a, b, result, result_hi;
  modport master (output kill, in_valid, op, a, b, out_ready, input in_ready, out_valid, result, result_hi, busy);
  modport slave (input kill, in_valid, op, a, b, out_ready, output in_ready, out_valid, result, result_hi, busy);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered single-cycle ALU plus iterative radix-2 mul/div with valid/ready handshakes
module alu_seq #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input logic clk,
  input logic rst_n,
  alu_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
  state_t state_q, state_d;
  logic [SHW-1:0] cnt_q, shamt;
  logic [2*WIDTH-1:0] acc_q, mul_next, div_next, mul_p;
  logic [WIDTH-1:0] d_q, result_q, result_hi_q, alu_y, abs_a, abs_b, quo, rem;
  logic [WIDTH:0] mul_sum, div_t, div_diff;
  logic out_valid_q, div_q, neg_lo_q, neg_hi_q;
  logic accept, md_op, is_div, is_sgn, sa, sb, dz;
  assign bus.in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready) && !bus.kill;
  assign bus.out_valid = out_valid_q;
  assign bus.result = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.busy = state_q == ITER;
  assign accept = bus.in_valid && bus.in_ready;
  assign md_op = bus.op inside {4'd10, 4'd11, 4'd12, 4'd13};
  assign is_div = bus.op[2];
  assign is_sgn = !bus.op[0];
  assign sa = is_sgn && bus.a[WIDTH-1];
  assign sb = is_sgn && bus.b[WIDTH-1];
  // Divide by zero keeps the raw dividend so the unsigned iteration yields all-ones / a directly.
  assign dz = is_div && (bus.b == '0);
  assign abs_a = (sa && !dz) ? -bus.a : bus.a;
  assign abs_b = sb ? -bus.b : bus.b;
  assign shamt = bus.a[SHW-1:0];
  // Multiply: {hi,lo} holds partial product over the shifting multiplier.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, d_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  // Divide: {rem,quo} shifts left; restore when the trial subtraction goes negative.
  assign div_t = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_t - {1'b0, d_q};
  assign div_next = div_diff[WIDTH] ? {div_t[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0} : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign mul_p = neg_lo_q ? -acc_q : acc_q;
  assign quo = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  // Single-cycle operation result, registered only on accept.
  always_comb begin
    alu_y = '0;
    case (bus.op)
      4'd0: alu_y = bus.a + bus.b;
      4'd1: alu_y = bus.a - bus.b;
      4'd2: alu_y = bus.a & bus.b;
      4'd3: alu_y = bus.a | bus.b;
      4'd4: alu_y = ~(bus.a | bus.b);
      4'd5: alu_y = bus.a ^ bus.b;
      4'd6: alu_y = bus.b << shamt;
      4'd7: alu_y = $signed(bus.b) >>> shamt;
      4'd8: alu_y = bus.b >> shamt;
      4'd9: alu_y = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      4'd14: alu_y = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
      default: alu_y = '0;
    endcase
  end
  // Next-state: kill wins, mul/div walk IDLE->ITER->FIX->IDLE.
  always_comb begin
    state_d = state_q;
    if (bus.kill) state_d = IDLE;
    else if (accept && md_op) state_d = ITER;
    else if (state_q == ITER && cnt_q == '0) state_d = FIX;
    else if (state_q == FIX) state_d = IDLE;
  end
  // State register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // Datapath: operand capture, iteration, sign fix-up and held output.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      acc_q <= '0;
      d_q <= '0;
      div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      out_valid_q <= 1'b0;
      result_q <= '0;
      result_hi_q <= '0;
    end else if (bus.kill) begin
      out_valid_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (accept && !md_op) begin
        result_q <= alu_y;
        result_hi_q <= '0;
        out_valid_q <= 1'b1;
      end else if (state_q == FIX) begin
        result_q <= div_q ? quo : mul_p[WIDTH-1:0];
        result_hi_q <= div_q ? rem : mul_p[2*WIDTH-1:WIDTH];
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) out_valid_q <= 1'b0;
      if (accept && md_op) begin
        cnt_q <= SHW'(WIDTH-1);
        acc_q <= {{WIDTH{1'b0}}, is_div ? abs_a : abs_b};
        d_q <= is_div ? abs_b : abs_a;
        div_q <= is_div;
        neg_lo_q <= (sa ^ sb) && !dz;
        neg_hi_q <= is_div ? (sa && !dz) : (sa ^ sb);
      end else if (state_q == ITER) begin
        acc_q <= div_q ? div_next : mul_next;
        cnt_q <= cnt_q - 1'b1;
      end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq
module tb_alu_seq;
  logic clk = 1'b0, rst_n = 1'b1;
  int checks = 0, failures = 0, n;
  alu_seq_if #(.WIDTH(32)) bus ();
  alu_seq #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    bus.op = o;
    bus.a = x;
    bus.b = y;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_ov(output int cnt);
    cnt = 0;
    while (!bus.out_valid && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask
  task automatic md(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] lo, input logic [31:0] hi);
    issue(o, x, y);
    bus.a = 32'hdead_beef;
    bus.b = 32'h0000_1234;
    chk({tag, "_busy"}, bus.busy, 1);
    chk({tag, "_inrdy"}, bus.in_ready, 0);
    wait_ov(n);
    chk({tag, "_lat"}, n, 33);
    chk({tag, "_lo"}, bus.result, lo);
    chk({tag, "_hi"}, bus.result_hi, hi);
    tick();
  endtask
  initial begin
    bus.kill = 0;
    bus.in_valid = 0;
    bus.op = 0;
    bus.a = 0;
    bus.b = 0;
    bus.out_ready = 0;
    #1 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_ov", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_res", bus.result, 0);
    chk("rst_hi", bus.result_hi, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rst_inrdy", bus.in_ready, 1);
    issue(4'd12, 32'hFFFF_FFF9, 32'd2);
    repeat (5) tick();
    chk("middiv_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_ov", bus.out_valid, 0);
    chk("arst_res", bus.result, 0);
    chk("arst_hi", bus.result_hi, 0);
    #1 rst_n = 1'b1;
    tick();
    chk("rel_inrdy", bus.in_ready, 1);
    repeat (40) tick();
    chk("rel_noresult", bus.out_valid, 0);
    bus.out_ready = 1;
    issue(4'd0, 32'd3, 32'd4);
    chk("add_ov", bus.out_valid, 1);
    chk("add_res", bus.result, 7);
    chk("add_hi", bus.result_hi, 0);
    issue(4'd1, 32'd5, 32'd7);
    chk("sub", bus.result, 32'hFFFF_FFFE);
    issue(4'd7, 32'h24, 32'h8000_0000);
    chk("sra", bus.result, 32'hF800_0000);
    issue(4'd14, 32'd1, 32'hFFFF_FFFF);
    chk("sltu", bus.result, 1);
    chk("b2b_ov", bus.out_valid, 1);
    issue(4'd9, 32'hFFFF_FFFF, 32'd1);
    chk("slt", bus.result, 1);
    issue(4'd6, 32'h21, 32'd1);
    chk("sll", bus.result, 2);
    issue(4'd4, 32'h0F0F_0000, 32'h0000_00FF);
    chk("nor", bus.result, 32'hF0F0_FF00);
    issue(4'd15, 32'd9, 32'd9);
    chk("op15", bus.result, 0);
    tick();
    chk("drain_ov", bus.out_valid, 0);
    md("mult", 4'd10, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 32'hFFFF_FFFF);
    md("multu", 4'd11, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 32'h0000_0002);
    md("div_neg", 4'd12, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    md("divu_z", 4'd13, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9);
    md("div_ovf", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    md("div_z", 4'd12, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
    md("divu", 4'd13, 32'd100, 32'd7, 32'd14, 32'd2);
    bus.out_ready = 0;
    issue(4'd0, 32'd10, 32'd20);
    bus.op = 4'd5;
    bus.a = 32'h0000_F0F0;
    bus.b = 32'h0000_FF00;
    bus.in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_inrdy", bus.in_ready, 0);
      chk("bp_ov", bus.out_valid, 1);
      chk("bp_res", bus.result, 30);
      tick();
    end
    bus.out_ready = 1;
    #1;
    chk("bp_release", bus.in_ready, 1);
    tick();
    bus.in_valid = 0;
    chk("bp_xor", bus.result, 32'h0000_0FF0);
    tick();
    issue(4'd10, 32'd5, 32'd7);
    repeat (9) tick();
    chk("kill_pre_busy", bus.busy, 1);
    bus.kill = 1;
    bus.op = 4'd0;
    bus.a = 32'd1;
    bus.b = 32'd1;
    bus.in_valid = 1;
    #1;
    chk("kill_inrdy", bus.in_ready, 0);
    tick();
    chk("kill_busy", bus.busy, 0);
    chk("kill_ov", bus.out_valid, 0);
    bus.kill = 0;
    bus.in_valid = 0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) n++;
      tick();
    end
    chk("kill_noresult", n, 0);
    issue(4'd0, 32'd1, 32'd1);
    chk("kill_after_ov", bus.out_valid, 1);
    chk("kill_after_res", bus.result, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
